canny_frame_ctrl: RTL and testbench

//  Frame-level sequencer and configuration block for the Canny edge pipeline. Holds the

---
 rtl/canny_frame_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_canny_frame_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/canny_frame_ctrl.sv
// Frame sequencer, threshold register block and per-frame statistics for the Canny pipeline.
// Optional auto-threshold feature: define CANNY_FRAME_CTRL_AUTO_TH_EN.
module canny_frame_ctrl #(
  parameter logic [9:0]  TH_LOW_RST  = 10'd50,
  parameter logic [9:0]  TH_HIGH_RST = 10'd100,
  parameter logic [31:0] TGT_HI      = 32'd20000,
  parameter logic [31:0] TGT_LO      = 32'd2000,
  parameter logic [9:0]  TH_STEP     = 10'd4
) (
  input  logic        clk,
  input  logic        rst_s,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  output logic [15:0] cfg_rdata,
  output logic        cfg_rvalid,
  input  logic        canny_vs,
  input  logic        canny_de,
  input  logic [7:0]  canny_out,
  output logic [9:0]  th_low,
  output logic [9:0]  th_high,
  output logic        canny_en,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, ARM, SYNC, ACTIVE} state_t;
  state_t state_reg, state_next;

  logic        enable_reg, single_reg, th_err_reg;
  logic        canny_en_reg, frame_done_reg, vs_d_reg, de_d_reg;
  logic [9:0]  sh_low_reg, sh_high_reg, th_low_reg, th_high_reg;
  logic [31:0] edge_work_reg, edge_lat_reg;
  logic [15:0] line_work_reg, line_lat_reg, frame_cnt_reg;
  logic [15:0] cfg_rdata_reg;
  logic        cfg_rvalid_reg;

  logic        vs_rise, vs_fall, wr_ctrl, commit, frame_end, stop, th_bad, auto_bit;
  logic        adj_en;
  logic [9:0]  adj_low, adj_high;
  logic [15:0] rd_mux;
  logic        unused_bits;

  assign vs_rise = canny_vs & ~vs_d_reg;
  assign vs_fall = ~canny_vs & vs_d_reg;
  assign wr_ctrl = cfg_wr && (cfg_addr == 3'd0);
  assign th_bad  = (sh_high_reg <= sh_low_reg);

`ifdef CANNY_FRAME_CTRL_AUTO_TH_EN
  logic        auto_reg;
  logic [10:0] hi_sum, lo_sum;
  logic [9:0]  hi_up, lo_up, hi_dn, lo_dn;

  assign auto_bit = auto_reg;

  // Raise: high saturates first, low is then kept strictly below it.
  // Lower: low floors at 1, high is then kept strictly above it.
  always_comb begin
    hi_sum = {1'b0, sh_high_reg} + {1'b0, TH_STEP};
    lo_sum = {1'b0, sh_low_reg} + {1'b0, TH_STEP};
    hi_up  = hi_sum[10] ? 10'd1023 : hi_sum[9:0];
    lo_up  = (lo_sum >= {1'b0, hi_up}) ? hi_up - 10'd1 : lo_sum[9:0];
    lo_dn  = (sh_low_reg > TH_STEP) ? sh_low_reg - TH_STEP : 10'd1;
    hi_dn  = (sh_high_reg >= TH_STEP) ? sh_high_reg - TH_STEP : 10'd0;
    if (hi_dn <= lo_dn) hi_dn = lo_dn + 10'd1;
    adj_en   = 1'b0;
    adj_low  = sh_low_reg;
    adj_high = sh_high_reg;
    if (frame_end && auto_reg) begin
      if (edge_work_reg > TGT_HI) begin
        adj_en = 1'b1; adj_low = lo_up; adj_high = hi_up;
      end else if (edge_work_reg < TGT_LO) begin
        adj_en = 1'b1; adj_low = lo_dn; adj_high = hi_dn;
      end
    end
  end
  assign unused_bits = &{1'b0, cfg_wdata[15:10]};
`else
  assign auto_bit    = 1'b0;
  assign adj_en      = 1'b0;
  assign adj_low     = sh_low_reg;
  assign adj_high    = sh_high_reg;
  assign unused_bits = &{1'b0, cfg_wdata[15:10], cfg_wdata[4], ^TGT_HI, ^TGT_LO, ^TH_STEP};
`endif

  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    frame_end  = 1'b0;
    stop       = 1'b0;
    case (state_reg)
      IDLE:   if (enable_reg) state_next = ARM;
      ARM:    if (!enable_reg) state_next = IDLE;
              else if (!canny_vs) state_next = SYNC;
      SYNC:   if (vs_rise) begin
                commit = 1'b1; state_next = ACTIVE;
              end else if (!enable_reg) begin
                stop = 1'b1; state_next = IDLE;
              end
      ACTIVE: if (vs_fall) begin
                frame_end = 1'b1;
                if (single_reg || !enable_reg) begin
                  stop = 1'b1; state_next = IDLE;
                end else begin
                  state_next = SYNC;
                end
              end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 16'd0;
    case (cfg_addr)
      3'd0: rd_mux = {11'd0, auto_bit, 2'b00, single_reg, enable_reg};
      3'd1: rd_mux = {6'd0, sh_low_reg};
      3'd2: rd_mux = {6'd0, sh_high_reg};
      3'd3: rd_mux = {14'd0, th_err_reg, state_reg != IDLE};
      3'd4: rd_mux = edge_lat_reg[15:0];
      3'd5: rd_mux = edge_lat_reg[31:16];
      3'd6: rd_mux = frame_cnt_reg;
      3'd7: rd_mux = line_lat_reg;
      default: rd_mux = 16'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      enable_reg     <= 1'b0;
      single_reg     <= 1'b0;
      th_err_reg     <= 1'b0;
      canny_en_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      vs_d_reg       <= 1'b0;
      de_d_reg       <= 1'b0;
      sh_low_reg     <= TH_LOW_RST;
      sh_high_reg    <= TH_HIGH_RST;
      th_low_reg     <= TH_LOW_RST;
      th_high_reg    <= TH_HIGH_RST;
      edge_work_reg  <= 32'd0;
      edge_lat_reg   <= 32'd0;
      line_work_reg  <= 16'd0;
      line_lat_reg   <= 16'd0;
      frame_cnt_reg  <= 16'd0;
      cfg_rdata_reg  <= 16'd0;
      cfg_rvalid_reg <= 1'b0;
`ifdef CANNY_FRAME_CTRL_AUTO_TH_EN
      auto_reg       <= 1'b0;
`endif
    end else begin
      vs_d_reg       <= canny_vs;
      de_d_reg       <= canny_de;
      frame_done_reg <= frame_end;
      cfg_rvalid_reg <= cfg_rd;
      cfg_rdata_reg  <= cfg_rd ? rd_mux : 16'd0;

      if (wr_ctrl) begin
        enable_reg <= cfg_wdata[0];
        single_reg <= cfg_wdata[1];
`ifdef CANNY_FRAME_CTRL_AUTO_TH_EN
        auto_reg   <= cfg_wdata[4];
`endif
      end else if (stop && single_reg) begin
        enable_reg <= 1'b0;
      end

      if (commit && th_bad)               th_err_reg <= 1'b1;
      else if (wr_ctrl && cfg_wdata[3])   th_err_reg <= 1'b0;

      // CPU shadow writes take priority over the automatic adjustment.
      if (cfg_wr && cfg_addr == 3'd1) sh_low_reg <= cfg_wdata[9:0];
      else if (adj_en)                sh_low_reg <= adj_low;
      if (cfg_wr && cfg_addr == 3'd2) sh_high_reg <= cfg_wdata[9:0];
      else if (adj_en)                sh_high_reg <= adj_high;

      if (commit) begin
        if (!th_bad) begin
          th_low_reg  <= sh_low_reg;
          th_high_reg <= sh_high_reg;
        end
        canny_en_reg  <= 1'b1;
        edge_work_reg <= 32'd0;
        line_work_reg <= 16'd0;
      end else if (state_reg == ACTIVE && canny_vs) begin
        if (canny_de && canny_out == 8'hFF && edge_work_reg != 32'hFFFF_FFFF)
          edge_work_reg <= edge_work_reg + 32'd1;
        if (canny_de && !de_d_reg && line_work_reg != 16'hFFFF)
          line_work_reg <= line_work_reg + 16'd1;
      end
      if (stop) canny_en_reg <= 1'b0;

      if (frame_end) begin
        edge_lat_reg  <= edge_work_reg;
        line_lat_reg  <= line_work_reg;
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
      if (wr_ctrl && cfg_wdata[2]) begin
        edge_lat_reg  <= 32'd0;
        line_lat_reg  <= 16'd0;
        frame_cnt_reg <= 16'd0;
      end
    end
  end

  assign th_low     = th_low_reg;
  assign th_high    = th_high_reg;
  assign canny_en   = canny_en_reg;
  assign frame_done = frame_done_reg;
  assign cfg_rdata  = cfg_rdata_reg;
  assign cfg_rvalid = cfg_rvalid_reg;

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Directed bench for canny_frame_ctrl: register reads are scored through a queue by a monitor.
module tb_canny_frame_ctrl;
  logic        clk = 1'b0;
  logic        rst_s = 1'b1;
  logic        cfg_wr = 1'b0, cfg_rd = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [15:0] cfg_wdata = 16'd0;
  logic [15:0] cfg_rdata;
  logic        cfg_rvalid;
  logic        canny_vs = 1'b0, canny_de = 1'b0;
  logic [7:0]  canny_out = 8'd0;
  logic [9:0]  th_low, th_high;
  logic        canny_en, frame_done;

  int n_cmp = 0, n_err = 0, cyc = 0, fd_cnt = 0, fd_base = 0;
  logic [15:0] exp_q[$];
  int          cyc_q[$];
  int          addr_q[$];

  canny_frame_ctrl dut (
    .clk(clk), .rst_s(rst_s), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
    .canny_vs(canny_vs), .canny_de(canny_de), .canny_out(canny_out),
    .th_low(th_low), .th_high(th_high), .canny_en(canny_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  // Read-data monitor: each rvalid must match the oldest queued read, one cycle after issue.
  always @(negedge clk) begin
    if (!rst_s && cfg_rvalid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rvalid: got rdata=%h with no read pending (cyc %0d)", cfg_rdata, cyc);
      end else begin
        logic [15:0] e;
        int c, a;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        a = addr_q.pop_front();
        if (cfg_rdata !== e || cyc != c + 1) begin
          n_err++;
          $display("FAIL read_addr%0d: got %h at cyc %0d, want %h at cyc %0d", a, cfg_rdata, cyc, e, c + 1);
        end else begin
          $display("read addr%0d -> %h ok", a, cfg_rdata);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end else begin
      $display("check %s = %0d ok", nm, act);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
    $display("write addr%0d <- %h", a, d);
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e);
    @(posedge clk); #1;
    cfg_rd = 1'b1; cfg_addr = a;
    exp_q.push_back(e); cyc_q.push_back(cyc); addr_q.push_back(int'(a));
    @(posedge clk); #1;
    cfg_rd = 1'b0;
  endtask

  task automatic rw(input logic [2:0] a, input logic [15:0] d, input logic [15:0] e);
    @(posedge clk); #1;
    cfg_rd = 1'b1; cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    exp_q.push_back(e); cyc_q.push_back(cyc); addr_q.push_back(int'(a));
    @(posedge clk); #1;
    cfg_rd = 1'b0; cfg_wr = 1'b0;
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    canny_vs = 1'b1;
    idle(2);
  endtask

  task automatic do_lines(input int lines, input int px, input int nedge);
    int cnt;
    cnt = 0;
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < px; p++) begin
        @(posedge clk); #1;
        canny_de  = 1'b1;
        canny_out = (cnt < nedge) ? 8'hFF : 8'h10;
        cnt++;
      end
      @(posedge clk); #1;
      canny_de = 1'b0; canny_out = 8'h00;
      @(posedge clk);
    end
  endtask

  task automatic end_frame(input logic exp_done);
    @(posedge clk); #1;
    canny_vs = 1'b0;
    @(negedge clk); chk("frame_done_before", frame_done, 0);
    @(negedge clk); chk("frame_done_pulse", frame_done, exp_done);
    @(negedge clk); chk("frame_done_after", frame_done, 0);
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(3);
    @(posedge clk); #1; rst_s = 1'b0;
    @(negedge clk);
    chk("rst_th_low", th_low, 50);
    chk("rst_th_high", th_high, 100);
    chk("rst_canny_en", canny_en, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_rvalid", cfg_rvalid, 0);
    rd(3'd1, 16'd50);
    rd(3'd2, 16'd100);
    rd(3'd3, 16'd0);
    rd(3'd6, 16'd0);

    // Enable, then a 4x8 frame with 5 edge pixels; thresholds written mid-frame
    wr(3'd0, 16'h0001);
    idle(4);
    chk("armed_canny_en", canny_en, 0);
    rd(3'd3, 16'd1);
    start_frame();
    wr(3'd1, 16'd30);
    wr(3'd2, 16'd80);
    chk("midframe_th_low", th_low, 50);
    chk("midframe_th_high", th_high, 100);
    chk("frame_canny_en", canny_en, 1);
    do_lines(4, 8, 5);
    end_frame(1'b1);
    chk("post_frame_th_low", th_low, 50);
    rd(3'd4, 16'd5);
    rd(3'd5, 16'd0);
    rd(3'd7, 16'd4);
    rd(3'd6, 16'd1);

    // Next frame commits 30/80
    start_frame();
    chk("commit_th_low", th_low, 30);
    chk("commit_th_high", th_high, 80);
    do_lines(2, 4, 0);
    end_frame(1'b1);
    rd(3'd4, 16'd0);
    rd(3'd7, 16'd2);
    rd(3'd6, 16'd2);

    // Invalid pair: high <= low keeps previous commit and sets th_err
    wr(3'd2, 16'd20);
    start_frame();
    chk("bad_th_low", th_low, 30);
    chk("bad_th_high", th_high, 80);
    rd(3'd3, 16'd3);
    end_frame(1'b1);
    wr(3'd0, 16'h0009);
    rd(3'd3, 16'd1);
    wr(3'd2, 16'd80);
    rw(3'd1, 16'd40, 16'd30);
    rd(3'd1, 16'd40);

    // Statistics clear is self-clearing
    wr(3'd0, 16'h0005);
    rd(3'd6, 16'd0);
    rd(3'd4, 16'd0);
    rd(3'd0, 16'd1);

    // Enable dropped mid-frame: frame completes, then idle
    start_frame();
    chk("frameD_th_low", th_low, 40);
    chk("frameD_th_high", th_high, 80);
    wr(3'd0, 16'h0000);
    chk("disable_midframe_en", canny_en, 1);
    do_lines(3, 4, 2);
    end_frame(1'b1);
    chk("disabled_canny_en", canny_en, 0);
    rd(3'd4, 16'd2);
    rd(3'd7, 16'd3);
    rd(3'd6, 16'd1);
    rd(3'd3, 16'd0);

    // Single-shot over three frames; first is empty
    fd_base = fd_cnt;
    wr(3'd0, 16'h0003);
    idle(4);
    start_frame();
    chk("single_canny_en", canny_en, 1);
    end_frame(1'b1);
    chk("single_en_after", canny_en, 0);
    for (int f = 0; f < 2; f++) begin
      start_frame();
      chk("single_en_idle", canny_en, 0);
      idle(3);
      end_frame(1'b0);
    end
    chk("single_done_count", fd_cnt - fd_base, 1);
    rd(3'd0, 16'd2);
    rd(3'd6, 16'd2);
    rd(3'd4, 16'd0);
    rd(3'd7, 16'd0);

    // Asynchronous reset mid-frame
    wr(3'd1, 16'd60);
    wr(3'd0, 16'h0001);
    idle(4);
    start_frame();
    chk("pre_reset_canny_en", canny_en, 1);
    @(posedge clk); #1; rst_s = 1'b1;
    #1;
    chk("async_rst_canny_en", canny_en, 0);
    chk("async_rst_th_low", th_low, 50);
    chk("async_rst_th_high", th_high, 100);
    @(posedge clk); #1; rst_s = 1'b0; canny_vs = 1'b0;
    idle(2);
    rd(3'd3, 16'd0);
    rd(3'd6, 16'd0);
    rd(3'd1, 16'd50);

    idle(3);
    chk("read_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
